// File: rtl/uart_irq_handler_if.sv
// Interrupt handler bus: UART source levels and controls in, CPU-facing interrupt status out.
interface uart_irq_handler_if #(
    parameter int NUM_SRC = 5,
    parameter int ID_W    = 3
);
    logic [NUM_SRC-1:0] src_lvl;
    logic [NUM_SRC-1:0] src_mask;
    logic               irq_ack;
    logic               lost_clr;
    logic               irq;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] irq_pending;
    logic [NUM_SRC-1:0] irq_lost;

    // Side driving the sources, mask and acknowledge (UART block / CPU)
    modport master (
        output src_lvl, src_mask, irq_ack, lost_clr,
        input  irq, irq_id, irq_pending, irq_lost
    );

    // Interrupt handler side
    modport slave (
        input  src_lvl, src_mask, irq_ack, lost_clr,
        output irq, irq_id, irq_pending, irq_lost
    );
endinterface

// File: rtl/uart_irq_handler.sv
// UART interrupt controller: rising-edge capture into a pending register,
// fixed-priority or round-robin arbitration, and an IDLE/ACTIVE/GAP handshake
// that holds irq/irq_id until acknowledged and forces one idle cycle between interrupts.
module uart_irq_handler #(
    parameter int NUM_SRC     = 5,
    parameter int ID_W        = 3,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic              pclk,
    input  logic              preset,
    uart_irq_handler_if.slave bus
);

    localparam int unsigned N = NUM_SRC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state_q;
    logic               irq_q;
    logic [ID_W-1:0]    irq_id_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] lost_q;
    logic [NUM_SRC-1:0] lost_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] eligible;
    logic               ack_fire;
    logic               any_eligible;
    logic [ID_W-1:0]    winner;
    int unsigned        start;
    int unsigned        idx;

    // Qualified rising edges and the one-hot clear of the acknowledged source
    always_comb begin
        rise     = bus.src_lvl & ~src_q & bus.src_mask;
        ack_fire = (state_q == ACTIVE) && bus.irq_ack;
        ack_clr  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ack_fire && (irq_id_q == ID_W'(i))) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // Next pending/lost state: a new edge beats a same-cycle clear, and such an
    // edge is not a loss because the old request was just serviced
    always_comb begin
        pending_d = (pending_q & ~ack_clr) | rise;
        lost_d    = (bus.lost_clr ? '0 : lost_q) | (rise & pending_q & ~ack_clr);
    end

    // Arbiter: scan from index 0 (fixed) or from rr_ptr with wrap (round-robin)
    always_comb begin
        eligible     = pending_q & bus.src_mask;
        any_eligible = |eligible;
        winner       = '0;
        start        = ROUND_ROBIN ? 32'(rr_ptr_q) : 32'd0;
        idx          = 0;
        for (int unsigned k = N; k > 0; k--) begin
            // Scanning downward with overwrite leaves the first hit in scan order
            idx = start + k - 1;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (eligible[idx]) begin
                winner = ID_W'(idx);
            end
        end
    end

    // Round-robin pointer advances past the source just serviced
    always_comb begin
        rr_ptr_d = (irq_id_q == ID_W'(N - 1)) ? '0 : irq_id_q + ID_W'(1);
    end

    // Edge detector history plus pending and lost registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            src_q     <= '0;
            pending_q <= '0;
            lost_q    <= '0;
        end else begin
            src_q     <= bus.src_lvl;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    // Interrupt handshake FSM with registered irq, irq_id and rr pointer
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_eligible) begin
                        irq_id_q <= winner;
                        irq_q    <= 1'b1;
                        state_q  <= ACTIVE;
                    end else begin
                        irq_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (bus.irq_ack) begin
                        irq_q   <= 1'b0;
                        state_q <= GAP;
                        if (ROUND_ROBIN) begin
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end
                end
                GAP: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq         = irq_q;
    assign bus.irq_id      = irq_id_q;
    assign bus.irq_pending = pending_q;
    assign bus.irq_lost    = lost_q;

endmodule
